axi_burst_write_master: RTL and testbench
=========================================

// Module: axi_burst_write_master
// PURPOSE
//  AXI write-channel master that issues INCR bursts into the slave-side write handler and
//  its memory write port. A local requester (DMA engine / CPU store path) gives address+length;
//  payload is pulled beat-by-beat from a streaming source.
//  Sequences AW -> W (burst) -> B, then reports completion with an error flag.
// PARAMETERS
//  MST_ID   4'd1    fixed AWID driven on every burst
//  MAX_LEN  4'd15   largest accepted req_len (beats-1); larger requests are rejected
// PORTS
//  ACLK      in   1   clock
//  ARESETn   in   1   asynchronous, active-low reset
//  req_valid in   1   burst request valid
//  req_ready out  1   request accepted when req_valid&&req_ready
//  req_addr  in   32  byte start address, must be word aligned
//  req_len   in   4   beats-1 (0..15)
//  wd_valid  in   1   payload beat valid
//  wd_ready  out  1   payload beat consumed when wd_valid&&wd_ready
//  wd_data   in   32  payload data
//  wd_strb   in   4   payload byte strobes
//  done      out  1   one-cycle pulse: burst finished or request rejected
//  done_err  out  1   qualified by done: 1 = rejected or BRESP!=OKAY
//  AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out, AWREADY in   AXI write address (AXI_define widths)
//  WDATA/WSTRB/WLAST/WVALID out, WREADY in                    AXI write data
//  BID/BRESP/BVALID in, BREADY out                            AXI write response
// BEHAVIOUR
//  - Reset (ARESETn=0, any time incl. mid-burst): state=IDLE; AWVALID, WVALID, WLAST, BREADY,
//    done, done_err, req_ready, wd_ready = 0; AWADDR/AWLEN = 0; beat counter = 0. No burst resumes.
//  - AWSIZE = 3'b010 (4 B) and AWBURST = 2'b01 (INCR), constant. AWID = MST_ID.
//  - FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
//    IDLE: req_ready=1 (0 while ARESETn low). On accept, latch addr/len.
//      Reject if addr[1:0]!=0, req_len>MAX_LEN, or addr[11:0]+(len+1)*4 > 4096 (13-bit sum).
//      Reject: next cycle done=1, done_err=1, stay IDLE, no AXI traffic.
//      Otherwise go to ADDR.
//    ADDR: AWVALID=1 (registered, first high 1 cycle after accept). AWADDR/AWLEN are stable until
//      AWVALID&&AWREADY, and AWVALID is never retracted. On the handshake go to DATA with beat_cnt=0.
//    DATA: WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB=wd_data/wd_strb combinational pass-through.
//      WLAST = (beat_cnt==len). beat_cnt increments on WVALID&&WREADY.
//      On the last-beat handshake go to RESP. Source bubbles (wd_valid=0) stall with no beat lost.
//    RESP: BREADY=1. On BVALID: latch err = (BRESP!=2'b00) || (BID!=MST_ID).
//      Next cycle done=1 with done_err=err, state IDLE; req_ready may be 1 in that same cycle.
//  - Minimum latency for a single beat with all readies high: accept@N, AW hs@N+1, W hs@N+2,
//    B hs@N+3, done@N+4.
//  - beat_cnt is 4-bit and never wraps: max 15 equals the last beat.
//  - WVALID is never asserted before the AW handshake completes. BREADY is low outside RESP.
//  - done is high only in the cycle after completion or rejection.
// STRUCTURE
//  - The AXI width macros and the OKAY/INCR/size-4 constants stay in the shared AXI define package.
//  - The state enum {IDLE,ADDR,DATA,RESP} also goes in that package.
//  - Single module: FSM, 4-bit beat counter, request/err registers. No sub-module is needed.
// TESTING
//  - Single beat: addr=0x1000, len=0, data=0xDEADBEEF, strb=4'hF, readies=1
//    -> AWADDR=0x1000, AWLEN=0, one W beat with WLAST=1, done@N+4, done_err=0.
//  - 16-beat burst: addr=0x2000, len=15, data=i, AWREADY delayed 3 cycles
//    -> AW held stable; 16 beats with WLAST only on beat 15; no W before the AW handshake.
//  - Backpressure: WREADY toggles 1,0,1,0 and wd_valid has 2-cycle gaps, len=3
//    -> exactly 4 beats, data order 0..3, no duplicates.
//  - Rejects: addr=0x1003; addr=0x0FF8 with len=3 (crosses 4 KB)
//    -> done=1, done_err=1 the next cycle, AWVALID never asserted.
//  - Slave error: BRESP=2'b10 on an otherwise good burst -> done_err=1; next request accepted normally.
//  - Reset asserted in DATA after beat 2 of len=7 -> all outputs 0 immediately;
//    after release a fresh request completes cleanly.

Source files
------------

// File: rtl/axi_burst_write_master_pkg.sv
// Shared AXI write-channel widths, encodings, burst FSM states and request-check helper.
// Pure declarations: no latency, no flow control.
package axi_burst_write_master_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [3:0]            len;
  } burst_req_t;

  // Only the low 12 address bits matter: a burst may not run past the end of its 4 KB page.
  function automatic logic burst_reject(input logic [11:0] addr_lo,
                                        input logic [3:0]  len,
                                        input logic [3:0]  max_len);
    logic [12:0] end_off;
    end_off = {1'b0, addr_lo} + (({9'd0, len} + 13'd1) << 2);
    return (addr_lo[1:0] != 2'b00) || (len > max_len) || (end_off > 13'd4096);
  endfunction

endpackage

// File: rtl/axi_burst_write_master.sv
// AXI INCR write master: request -> AW -> W burst -> B -> done/done_err pulse.
// Latency: single beat with all readies high gives done 4 cycles after request accept.
// Backpressure: req_ready only in IDLE; payload stalls on wd_valid low or WREADY low, no beat lost.
module axi_burst_write_master
  import axi_burst_write_master_pkg::*;
#(
  parameter logic [3:0] MST_ID  = 4'd1,
  parameter logic [3:0] MAX_LEN = 4'd15
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AXI_ADDR_W-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [AXI_DATA_W-1:0] wd_data,
  input  logic [AXI_STRB_W-1:0] wd_strb,
  output logic                  done,
  output logic                  done_err,
  output logic [AXI_ID_W-1:0]   AWID,
  output logic [AXI_ADDR_W-1:0] AWADDR,
  output logic [AXI_LEN_W-1:0]  AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AXI_DATA_W-1:0] WDATA,
  output logic [AXI_STRB_W-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [AXI_ID_W-1:0]   BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  wr_state_e  state;
  burst_req_t req_q;
  logic [3:0] beat_cnt;
  logic       in_data;

  assign in_data   = (state == ST_DATA);
  assign req_ready = ARESETn && (state == ST_IDLE);

  // AW fields come straight from the latched request, so they cannot move while AWVALID waits.
  assign AWID    = MST_ID;
  assign AWADDR  = req_q.addr;
  assign AWLEN   = {4'd0, req_q.len};
  assign AWSIZE  = AXI_SIZE_4B;
  assign AWBURST = AXI_BURST_INCR;
  assign AWVALID = (state == ST_ADDR);

  assign WVALID   = in_data && wd_valid;
  assign wd_ready = in_data && WREADY;
  assign WDATA    = wd_data;
  assign WSTRB    = wd_strb;
  assign WLAST    = in_data && (beat_cnt == req_q.len);
  assign BREADY   = (state == ST_RESP);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      beat_cnt <= 4'd0;
      done     <= 1'b0;
      done_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            if (burst_reject(req_addr[11:0], req_len, MAX_LEN)) begin
              done     <= 1'b1;
              done_err <= 1'b1;
            end else begin
              req_q.addr <= req_addr;
              req_q.len  <= req_len;
              state      <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (AWREADY) begin
            beat_cnt <= 4'd0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The last beat leaves the counter at len, so it never wraps past 15.
          if (WVALID && WREADY) begin
            if (WLAST) state <= ST_RESP;
            else       beat_cnt <= beat_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (BVALID) begin
            done     <= 1'b1;
            done_err <= (BRESP != AXI_RESP_OKAY) || (BID != MST_ID);
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed and randomized bursts against a request-level reference model with an AXI slave/source.
module tb_axi_burst_write_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        done, done_err;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  axi_burst_write_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .done(done), .done_err(done_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Observations gathered on the falling edge, plus slave/source configuration.
  int          cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
  int          aw_cnt = 0, aw_wait = 0, viol = 0, gap_left = 0;
  bit          aw_pend = 0, aw_done = 0, b_phase = 0, done_err_s = 0, wr_tog = 0;
  bit          src_hs = 0, b_hs = 0;
  logic [31:0] aw_addr_h = '0;
  logic [7:0]  aw_len_h = '0;
  logic [36:0] w_q[$];
  logic [35:0] src_q[$];
  int          aw_delay = 0, wr_mode = 0, src_gap = 0;
  bit          src_rand = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [3:0]  cfg_bid = 4'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    aw_cnt = 0; aw_wait = 0; viol = 0; gap_left = 0;
    aw_pend = 0; aw_done = 0; b_phase = 0; wr_tog = 0;
    w_q.delete();
  endtask

  // Monitor on the falling edge, slave responses and payload source just after the rising edge.
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BID = 0; BRESP = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
      if (AWVALID) begin
        if (AWSIZE !== 3'b010 || AWBURST !== 2'b01 || AWID !== 4'd1) viol++;
        if (aw_pend && (AWADDR !== aw_addr_h || AWLEN !== aw_len_h)) viol++;
        aw_addr_h = AWADDR;
        aw_len_h  = AWLEN;
        if (AWREADY) begin aw_cnt++; aw_done = 1; aw_pend = 0; aw_wait = 0; end
        else begin aw_pend = 1; aw_wait++; end
      end else if (aw_pend) viol++;
      if (WVALID && !aw_done) viol++;
      if (WVALID && WREADY) begin
        w_q.push_back({WDATA, WSTRB, WLAST});
        if (WLAST) b_phase = 1;
      end
      if (BREADY && !b_phase) viol++;
      b_hs = BVALID && BREADY;
      if (b_hs) b_phase = 0;
      if (done) begin done_cnt++; done_cyc = cyc; done_err_s = done_err; end
      src_hs = wd_valid && wd_ready;

      @(posedge ACLK);
      #1;
      if (src_hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gap_left = src_gap;
      end
      if (wd_valid && !src_hs && src_q.size() > 0) begin
        {wd_data, wd_strb} = src_q[0];
      end else if (gap_left > 0) begin
        gap_left--;
        wd_valid = 0;
        wd_data  = $urandom;
      end else if (src_q.size() > 0 && (!src_rand || $urandom_range(0, 1) == 1)) begin
        wd_valid = 1;
        {wd_data, wd_strb} = src_q[0];
      end else begin
        wd_valid = 0;
        wd_data  = $urandom;
      end
      AWREADY = AWVALID && (aw_wait >= aw_delay);
      case (wr_mode)
        0:       WREADY = 1;
        1:       begin wr_tog = !wr_tog; WREADY = wr_tog; end
        default: WREADY = 1'($urandom_range(0, 1));
      endcase
      if (b_hs) BVALID = 0;
      if (b_phase && !BVALID && !b_hs) begin
        BVALID = 1; BID = cfg_bid; BRESP = cfg_bresp;
      end
    end
  end

  task automatic check_quiet(input string nm);
    chk({nm, "_awvalid"}, AWVALID, 0);
    chk({nm, "_wvalid"}, WVALID, 0);
    chk({nm, "_wlast"}, WLAST, 0);
    chk({nm, "_bready"}, BREADY, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_done_err"}, done_err, 0);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_wd_ready"}, wd_ready, 0);
    chk({nm, "_awaddr"}, AWADDR, 0);
    chk({nm, "_awlen"}, AWLEN, 0);
  endtask

  // One request end to end; expectations come from the burst rules, not the DUT.
  task automatic do_req(input string nm, input logic [31:0] a, input logic [3:0] l,
                        input logic [1:0] br, input logic [3:0] bid, input bit seq,
                        input logic [31:0] base, input int lat_exp);
    logic [35:0] exp_q[$];
    logic [31:0] d;
    logic [3:0]  s;
    bit rej, exp_err;
    int acc0, done0, src0, t, nbeat;
    nbeat   = int'(l) + 1;
    rej     = (a[1:0] != 2'b00) || (int'(a[11:0]) + nbeat * 4 > 4096);
    exp_err = rej || (br != 2'b00) || (bid != 4'd1);
    clear_mon();
    cfg_bresp = br;
    cfg_bid   = bid;
    for (int i = 0; i < nbeat; i++) begin
      d = seq ? base + 32'(i) : $urandom;
      s = seq ? 4'hF : 4'($urandom_range(1, 15));
      exp_q.push_back({d, s});
      src_q.push_back({d, s});
    end
    src0  = src_q.size();
    acc0  = acc_cnt;
    done0 = done_cnt;
    req_addr  = a;
    req_len   = l;
    req_valid = 1;
    t = 0;
    while (acc_cnt == acc0 && t < 50) begin @(posedge ACLK); #1; t++; end
    req_valid = 0;
    chk({nm, "_accept"}, acc_cnt - acc0, 1);
    t = 0;
    while (done_cnt == done0 && t < 500) begin @(posedge ACLK); #1; t++; end
    chk({nm, "_done_seen"}, done_cnt - done0, 1);
    chk({nm, "_done_err"}, done_err_s, exp_err);
    if (rej) chk({nm, "_rej_latency"}, done_cyc - acc_cyc, 1);
    else if (lat_exp > 0) chk({nm, "_latency"}, done_cyc - acc_cyc, lat_exp);
    repeat (2) begin @(posedge ACLK); #1; end
    chk({nm, "_done_pulse"}, done_cnt - done0, 1);
    chk({nm, "_aw_count"}, aw_cnt, rej ? 0 : 1);
    if (!rej) begin
      chk({nm, "_awaddr"}, aw_addr_h, a);
      chk({nm, "_awlen"}, aw_len_h, {4'd0, l});
    end
    chk({nm, "_beats"}, w_q.size(), rej ? 0 : nbeat);
    if (!rej) begin
      for (int i = 0; i < nbeat && i < w_q.size(); i++)
        chk($sformatf("%s_beat%0d", nm, i), w_q[i], {exp_q[i], i == nbeat - 1});
      chk({nm, "_src_left"}, src_q.size(), 0);
    end else begin
      chk({nm, "_src_untouched"}, src_q.size(), src0);
      src_q.delete();
    end
    chk({nm, "_protocol"}, viol, 0);
  endtask

  initial begin
    int t;
    logic [31:0] ra;
    logic [3:0]  rl;
    logic [1:0]  rb;
    logic [3:0]  rd;
    ARESETn = 0; req_valid = 0; req_addr = '0; req_len = '0;
    #3;
    check_quiet("reset");
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1;
    @(posedge ACLK); #1;
    chk("req_ready_idle", req_ready, 1);

    do_req("single", 32'h0000_1000, 4'd0, 2'b00, 4'd1, 1, 32'hDEAD_BEEF, 4);

    aw_delay = 3;
    do_req("burst16", 32'h0000_2000, 4'd15, 2'b00, 4'd1, 1, 32'd0, 0);
    aw_delay = 0;

    wr_mode = 1; src_gap = 2;
    do_req("bp", 32'h0000_3000, 4'd3, 2'b00, 4'd1, 1, 32'd0, 0);
    wr_mode = 0; src_gap = 0;

    do_req("rej_misal", 32'h0000_1003, 4'd0, 2'b00, 4'd1, 0, 32'd0, 0);
    do_req("rej_4k", 32'h0000_0FF8, 4'd3, 2'b00, 4'd1, 0, 32'd0, 0);
    do_req("edge_4k", 32'h0000_5FC0, 4'd15, 2'b00, 4'd1, 0, 32'd0, 0);

    do_req("slverr", 32'h0000_4000, 4'd2, 2'b10, 4'd1, 0, 32'd0, 0);
    do_req("after_err", 32'h0000_4100, 4'd1, 2'b00, 4'd1, 0, 32'd0, 4 + 1);
    do_req("bid_bad", 32'h0000_4200, 4'd0, 2'b00, 4'd3, 0, 32'd0, 0);

    // Reset in the middle of the data phase of an 8-beat burst.
    clear_mon();
    cfg_bresp = 2'b00; cfg_bid = 4'd1;
    for (int i = 0; i < 8; i++) src_q.push_back({32'h100 + 32'(i), 4'hF});
    req_addr = 32'h0000_7000; req_len = 4'd7; req_valid = 1;
    t = 0;
    while (acc_cnt == 0 && t < 0) t++;
    t = 0;
    @(posedge ACLK); #1;
    req_valid = 0;
    while (w_q.size() < 3 && t < 100) begin @(posedge ACLK); #1; t++; end
    chk("rst_mid_beats_before", w_q.size(), 3);
    #2 ARESETn = 0;
    #1;
    check_quiet("rst_mid");
    repeat (3) @(posedge ACLK);
    #1;
    src_q.delete();
    clear_mon();
    @(posedge ACLK);
    #3 ARESETn = 1;
    @(posedge ACLK); #1;
    chk("rst_mid_no_resume", aw_cnt + w_q.size(), 0);
    do_req("post_rst", 32'h0000_6000, 4'd7, 2'b00, 4'd1, 1, 32'hA000, 0);

    wr_mode = 2; src_rand = 1;
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 7))
        0:       ra = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        1, 2:    begin ra = $urandom; ra[11:0] = 12'(4032 + 4 * $urandom_range(0, 15)); end
        default: ra = $urandom & 32'hFFFF_FFFC;
      endcase
      rl = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rd = ($urandom_range(0, 5) == 0) ? 4'd7 : 4'd1;
      aw_delay = $urandom_range(0, 3);
      src_gap  = $urandom_range(0, 2);
      do_req($sformatf("rnd%0d", k), ra, rl, rb, rd, 0, 32'd0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
